p4_router_ing_policer: RTL and testbench
========================================

// Module: p4_router_ing_policer
// PURPOSE
//  Per-ingress-port leaky-bucket policer between VNP4 wrapper output (classified packets) and queue-system enqueue.
//  Each port's bucket fills with accepted payload bytes and leaks by a configured decrement every tick.
//  Whole packets from a port whose bucket is at/above threshold at SOP are dropped; all others pass unchanged.
// PARAMETERS
//  NUM_ING_PORTS    4     ingress ports policed; bucket index = port field of tuser
//  DATA_BYTES       64    AXIS data bytes (tkeep width)
//  USER_WIDTH       64    AXIS tuser width (VNP4 wrapper metadata)
//  PORT_LSB         0     LSB of ingress-port field in tuser; field width $clog2(NUM_ING_PORTS)
//  TICK_CYCLES      16    clocks per leak tick (>=1)
// PORTS
//  core_clk            in   1                     core clock
//  core_arstn          in   1                     reset, asynchronous assert, active-low
//  packet_in           AXIS slave  DATA_BYTES/USER_WIDTH  classified packets
//  packet_out          AXIS master DATA_BYTES/USER_WIDTH  policed packets to queue system
//  policer_enable      in   NUM_ING_PORTS         per-port enable; 0 = never drop, bucket still tracks
//  bucket_decrement    in   bucket_decrement_t[N] bytes leaked per tick
//  bucket_threshold    in   bucket_depth_threshold_t[N] drop threshold
//  bucket_level        out  bucket_level_t[N]     current bucket fill
//  drop_pulse          out  NUM_ING_PORTS         1-cycle pulse on each dropped packet's SOP
// BEHAVIOUR
//  Reset: all levels 0, tick counter 0, state PASS, sop flag 1, packet_out.tvalid 0, packet_in.tready 0, drop_pulse 0.
//  FSM (single input stream): PASS / DROP. At an accepted SOP beat, port p = tuser[PORT_LSB+:log2N]:
//   policer_enable[p] && level[p] >= threshold[p] -> DROP, else PASS. State holds to tlast; sop flag set after tlast.
//  A single-beat packet (SOP & tlast) is decided and completed in the same cycle.
//  PASS: one register stage plus skid buffer; latency 1 cycle; full throughput; tready = !skid_full.
//   tdata/tkeep/tuser/tlast forwarded bit-exact.
//  DROP: packet_in.tready = 1 irrespective of packet_out; no beats emitted; dropped bytes not added to bucket.
//  Bucket update per port each cycle: lvl' = sat0_max(lvl - (tick ? dec : 0) + add);
//   add = popcount(tkeep) on accepted PASS beat for that port, else 0.
//   Arithmetic in LEVEL_W+2 signed; floor 0, ceiling all-ones; add and leak in same cycle both applied.
//  tick: asserted once every TICK_CYCLES clocks, all ports leak simultaneously.
//  Threshold 0 with enable = 1 drops every packet; decrement 0 means no leak.
//  Config inputs are quasi-static, sampled every cycle; a change mid-packet does not alter the current decision.
//  Port field >= NUM_ING_PORTS: packet passes, no bucket touched.
//  Reset mid-packet: state cleared; next accepted beat is treated as SOP (upstream shares reset).
// CONFIGURATION
//  `P4_ROUTER_ING_POLICER_STATS_EN defined:
//   adds outputs drop_pkt_cnt[N], drop_byte_cnt[N] (32b, wrap) and input stats_clear (1-cycle clear).
//   Counters increment on each dropped packet / dropped beat popcount; stats_clear wins over a same-cycle increment.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  p4_router_pkg: bucket_decrement_t, bucket_depth_threshold_t, bucket_level_t (LEVEL_W=24), policer_state_e {POL_PASS, POL_DROP}.
//  Sub-module p4_router_policer_bucket: one per port (generate).
//   Holds level, saturating add/leak, compare. Output over_thresh.
//  Top: tick prescaler, FSM, skid buffer, stats.
// TESTING
//  1. enable=0, 10x 256B pkts port 0 -> all pass bit-exact, latency 1, level[0]=2560 with dec=0.
//  2. thresh=1000, dec=0, port1 pkts 600B,600B,600B -> pkt3 dropped, drop_pulse[1] once, level[1]=1200.
//  3. dec=100, TICK_CYCLES=16, level 1200, idle 64 clk -> level 800; level 50 -> 0 (no underflow).
//  4. Add and tick in same cycle: level 500, beat 64B, dec=100 -> level 464.
//  5. packet_out.tready toggled 50% during PASS, then DROP packet -> no beat lost/duplicated.
//     Dropped packet drained at 1 beat/clk with tready=0 downstream.
//  6. Assert core_arstn mid-packet -> outputs reset values next edge; levels 0; following packet passes.
//     STATS_EN: drop_pkt_cnt/drop_byte_cnt match scenario 2 (1, 600), clear -> 0.

Source files
------------

// File: rtl/p4_router_pkg.sv
// p4_router_pkg: shared bucket types and policer state encoding for the ingress policer.
package p4_router_pkg;
    localparam int LEVEL_W = 24;

    typedef logic [LEVEL_W-1:0] bucket_decrement_t;
    typedef logic [LEVEL_W-1:0] bucket_depth_threshold_t;
    typedef logic [LEVEL_W-1:0] bucket_level_t;

    typedef enum logic {POL_PASS, POL_DROP} policer_state_e;
endpackage

// File: rtl/p4_router_ing_policer_if.sv
// p4_router_ing_policer_if: AXI-stream bundle carrying classified packets with tuser metadata.
interface p4_router_ing_policer_if #(
    parameter int DATA_BYTES = 64,
    parameter int USER_WIDTH = 64
);
    logic                    tvalid;
    logic                    tready;
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/p4_router_policer_bucket.sv
// p4_router_policer_bucket: one port's leaky bucket with saturating add/leak and threshold compare.
module p4_router_policer_bucket
    import p4_router_pkg::*;
#(
    parameter int ADD_W = 7
) (
    input  logic                    core_clk,
    input  logic                    core_arstn,
    input  logic                    tick,
    input  bucket_decrement_t       decrement,
    input  bucket_depth_threshold_t threshold,
    input  logic [ADD_W-1:0]        add,
    output bucket_level_t           level,
    output logic                    over_thresh
);
    logic [LEVEL_W-1:0]        leak;
    logic signed [LEVEL_W+1:0] nxt;

    assign leak        = tick ? decrement : '0;
    assign nxt         = $signed({2'b00, level}) - $signed({2'b00, leak}) + $signed((LEVEL_W+2)'(add));
    assign over_thresh = level >= threshold;

    // Top bit is the sign (floor at 0); next bit set means past the all-ones ceiling.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) level <= '0;
        else             level <= nxt[LEVEL_W+1] ? '0 : nxt[LEVEL_W] ? '1 : nxt[LEVEL_W-1:0];
    end
endmodule

// File: rtl/p4_router_ing_policer.sv
// p4_router_ing_policer: per-ingress-port leaky-bucket policer with whole-packet drop and 1-cycle skid path.
// Optional drop statistics enabled by defining P4_ROUTER_ING_POLICER_STATS_EN.
module p4_router_ing_policer
    import p4_router_pkg::*;
#(
    parameter int NUM_ING_PORTS = 4,
    parameter int DATA_BYTES    = 64,
    parameter int USER_WIDTH    = 64,
    parameter int PORT_LSB      = 0,
    parameter int TICK_CYCLES   = 16
) (
    input  logic                                         core_clk,
    input  logic                                         core_arstn,
    p4_router_ing_policer_if.slave                       packet_in,
    p4_router_ing_policer_if.master                      packet_out,
    input  logic [NUM_ING_PORTS-1:0]                     policer_enable,
    input  bucket_decrement_t [NUM_ING_PORTS-1:0]        bucket_decrement,
    input  bucket_depth_threshold_t [NUM_ING_PORTS-1:0]  bucket_threshold,
    output bucket_level_t [NUM_ING_PORTS-1:0]            bucket_level,
    output logic [NUM_ING_PORTS-1:0]                     drop_pulse
`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    ,
    input  logic                                         stats_clear,
    output logic [NUM_ING_PORTS-1:0][31:0]               drop_pkt_cnt,
    output logic [NUM_ING_PORTS-1:0][31:0]               drop_byte_cnt
`endif
);
    localparam int PW = NUM_ING_PORTS > 1 ? $clog2(NUM_ING_PORTS) : 1;
    localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int KW = $clog2(DATA_BYTES + 1);

    logic [CW-1:0]            tick_cnt;
    logic                     tick;
    logic [PW-1:0]            port, pkt_port, cur_port;
    logic                     port_ok, pkt_ok, cur_ok;
    logic [KW-1:0]            nbytes;
    logic [NUM_ING_PORTS-1:0] over;
    policer_state_e           state;
    logic                     sop, run;
    logic                     drop_sop, drop_beat, in_rdy, acc, acc_pass, o_free;

    logic                    o_v, o_last, s_v, s_last;
    logic [8*DATA_BYTES-1:0] o_data, s_data;
    logic [DATA_BYTES-1:0]   o_keep, s_keep;
    logic [USER_WIDTH-1:0]   o_user, s_user;

    assign tick     = tick_cnt == CW'(TICK_CYCLES - 1);
    assign port     = packet_in.tuser[PORT_LSB +: PW];
    assign port_ok  = {1'b0, port} < (PW+1)'(NUM_ING_PORTS);
    assign cur_port = sop ? port : pkt_port;
    assign cur_ok   = sop ? port_ok : pkt_ok;
    assign drop_sop = sop && port_ok && policer_enable[port] && over[port];
    assign drop_beat = sop ? drop_sop : state == POL_DROP;
    // A dropping packet drains regardless of the downstream skid state.
    assign in_rdy   = run && (!s_v || drop_beat);
    assign acc      = packet_in.tvalid && in_rdy;
    assign acc_pass = acc && !drop_beat;
    assign o_free   = !o_v || packet_out.tready;

    assign packet_in.tready  = in_rdy;
    assign packet_out.tvalid = o_v;
    assign packet_out.tdata  = o_data;
    assign packet_out.tkeep  = o_keep;
    assign packet_out.tuser  = o_user;
    assign packet_out.tlast  = o_last;

    always_comb begin
        nbytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) nbytes = nbytes + KW'(packet_in.tkeep[i]);
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) tick_cnt <= '0;
        else             tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_ING_PORTS; i++) begin : g_bkt
        p4_router_policer_bucket #(.ADD_W(KW)) u_bkt (
            .core_clk    (core_clk),
            .core_arstn  (core_arstn),
            .tick        (tick),
            .decrement   (bucket_decrement[i]),
            .threshold   (bucket_threshold[i]),
            .add         ((acc_pass && cur_ok && cur_port == PW'(i)) ? nbytes : '0),
            .level       (bucket_level[i]),
            .over_thresh (over[i])
        );
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state      <= POL_PASS;
            sop        <= 1'b1;
            run        <= 1'b0;
            pkt_port   <= '0;
            pkt_ok     <= 1'b0;
            drop_pulse <= '0;
        end else begin
            run        <= 1'b1;
            drop_pulse <= (acc && drop_sop) ? NUM_ING_PORTS'(1) << port : '0;
            if (acc) begin
                state    <= packet_in.tlast ? POL_PASS : drop_beat ? POL_DROP : POL_PASS;
                sop      <= packet_in.tlast;
                pkt_port <= cur_port;
                pkt_ok   <= cur_ok;
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            {o_v, o_last, o_data, o_keep, o_user} <= '0;
            {s_v, s_last, s_data, s_keep, s_user} <= '0;
        end else if (o_free) begin
            if (s_v) begin
                {o_v, o_last, o_data, o_keep, o_user} <= {1'b1, s_last, s_data, s_keep, s_user};
                s_v <= 1'b0;
            end else begin
                o_v <= acc_pass;
                if (acc_pass)
                    {o_last, o_data, o_keep, o_user} <= {packet_in.tlast, packet_in.tdata, packet_in.tkeep, packet_in.tuser};
            end
        end else if (acc_pass) begin
            {s_v, s_last, s_data, s_keep, s_user} <= {1'b1, packet_in.tlast, packet_in.tdata, packet_in.tkeep, packet_in.tuser};
        end
    end

`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    for (genvar i = 0; i < NUM_ING_PORTS; i++) begin : g_stats
        always_ff @(posedge core_clk or negedge core_arstn) begin
            if (!core_arstn || stats_clear) begin
                drop_pkt_cnt[i]  <= '0;
                drop_byte_cnt[i] <= '0;
            end else if (acc && drop_beat && cur_port == PW'(i)) begin
                drop_pkt_cnt[i]  <= drop_pkt_cnt[i] + 32'(sop);
                drop_byte_cnt[i] <= drop_byte_cnt[i] + 32'(nbytes);
            end
        end
    end
`endif
endmodule

// File: tb/tb_p4_router_ing_policer.sv
// tb_p4_router_ing_policer: scoreboard bench for the ingress policer (pass path, buckets, drops, reset).
module tb_p4_router_ing_policer;
    import p4_router_pkg::*;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [63:0]  user;
        logic         last;
        int           acc;
        bit           lat;
    } beat_t;

    logic core_clk = 0;
    logic core_arstn = 0;
    logic [3:0] policer_enable;
    bucket_decrement_t [3:0] bucket_decrement;
    bucket_depth_threshold_t [3:0] bucket_threshold;
    bucket_level_t [3:0] bucket_level;
    logic [3:0] drop_pulse;
`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    logic stats_clear = 0;
    logic [3:0][31:0] drop_pkt_cnt, drop_byte_cnt;
`endif

    p4_router_ing_policer_if #(.DATA_BYTES(64), .USER_WIDTH(64)) in_if ();
    p4_router_ing_policer_if #(.DATA_BYTES(64), .USER_WIDTH(64)) out_if ();

    p4_router_ing_policer #(
        .NUM_ING_PORTS(4), .DATA_BYTES(64), .USER_WIDTH(64), .PORT_LSB(0), .TICK_CYCLES(16)
    ) dut (
        .core_clk         (core_clk),
        .core_arstn       (core_arstn),
        .packet_in        (in_if),
        .packet_out       (out_if),
        .policer_enable   (policer_enable),
        .bucket_decrement (bucket_decrement),
        .bucket_threshold (bucket_threshold),
        .bucket_level     (bucket_level),
        .drop_pulse       (drop_pulse)
`ifdef P4_ROUTER_ING_POLICER_STATS_EN
        ,
        .stats_clear      (stats_clear),
        .drop_pkt_cnt     (drop_pkt_cnt),
        .drop_byte_cnt    (drop_byte_cnt)
`endif
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int pulses [4] = '{0, 0, 0, 0};
    int f_acc, l_acc;
    beat_t sb [$];

    always @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge core_clk) begin
        #1;
        out_if.tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge core_clk) begin
        beat_t e;
        for (int i = 0; i < 4; i++) if (drop_pulse[i] === 1'b1) pulses[i]++;
        if (core_arstn && out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got beat user=%h keep=%h last=%b, required none", out_if.tuser, out_if.tkeep, out_if.tlast);
            end else begin
                e = sb.pop_front();
                if ({out_if.tdata, out_if.tkeep, out_if.tuser, out_if.tlast} !== {e.data, e.keep, e.user, e.last} ||
                    (e.lat && cyc != e.acc + 1)) begin
                    errors++;
                    $display("FAIL sb_beat: got user=%h keep=%h last=%b d=%h cyc=%0d, required user=%h keep=%h last=%b d=%h cyc=%0d",
                             out_if.tuser, out_if.tkeep, out_if.tlast, out_if.tdata[63:0], cyc,
                             e.user, e.keep, e.last, e.data[63:0], e.acc + 1);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic send_pkt(input int port, input int bytes, input bit drop, input bit lat, input int stop,
                            output int first, output int last);
        int nb, n, rem, t;
        logic [511:0] d;
        logic [63:0] k, u;
        nb = (bytes + 63) / 64;
        n = (stop > 0 && stop < nb) ? stop : nb;
        first = -1;
        last = -1;
        @(posedge core_clk); #1;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            rem = bytes - b * 64;
            k = '0;
            for (int i = 0; i < 64; i++) if (i < rem) k[i] = 1'b1;
            u = {$urandom, $urandom};
            u[1:0] = port[1:0];
            in_if.tvalid = 1'b1;
            in_if.tdata = d;
            in_if.tkeep = k;
            in_if.tuser = u;
            in_if.tlast = (b == nb - 1);
            t = 0;
            @(negedge core_clk);
            while (in_if.tready !== 1'b1 && t < 500) begin
                t++;
                @(negedge core_clk);
            end
            checks++;
            if (in_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL accept_timeout: got tready=%b, required 1 within 500 cycles", in_if.tready);
                break;
            end
            if (!drop) sb.push_back('{d, k, u, b == nb - 1, cyc, lat});
            if (b == 0) first = cyc;
            last = cyc;
            @(posedge core_clk); #1;
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            t++;
            @(negedge core_clk);
        end
        repeat (2) @(negedge core_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        in_if.tvalid = 1'b0;
        in_if.tdata = '0;
        in_if.tkeep = '0;
        in_if.tuser = '0;
        in_if.tlast = 1'b0;
        policer_enable = '0;
        bucket_decrement = '0;
        bucket_threshold = '1;
        repeat (3) @(negedge core_clk);
        checks += 4;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", out_if.tvalid); end
        if (in_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", in_if.tready); end
        if (bucket_level !== '0) begin errors++; $display("FAIL rst_level: got %h, required 0", bucket_level); end
        if (drop_pulse !== '0) begin errors++; $display("FAIL rst_drop_pulse: got %b, required 0", drop_pulse); end
        core_arstn = 1'b1;
        @(negedge core_clk);
        checks++;
        if (in_if.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b, required 1", in_if.tready); end
    endtask

    task automatic test_pass_bitexact();
        for (int i = 0; i < 10; i++) send_pkt(0, 256, 0, 1, 0, f_acc, l_acc);
        wait_drain("pass");
        checks++;
        if (bucket_level[0] !== 24'd2560) begin errors++; $display("FAIL pass_level0: got %0d, required 2560", bucket_level[0]); end
    endtask

    task automatic test_threshold_drop();
        policer_enable[1] = 1'b1;
        bucket_threshold[1] = 24'd1000;
        send_pkt(1, 600, 0, 1, 0, f_acc, l_acc);
        send_pkt(1, 600, 0, 1, 0, f_acc, l_acc);
        send_pkt(1, 600, 1, 1, 0, f_acc, l_acc);
        wait_drain("thresh");
        checks += 2;
        if (pulses[1] != 1) begin errors++; $display("FAIL thresh_pulse: got %0d pulses, required 1", pulses[1]); end
        if (bucket_level[1] !== 24'd1200) begin errors++; $display("FAIL thresh_level1: got %0d, required 1200", bucket_level[1]); end
    endtask

`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    task automatic test_stats();
        checks += 2;
        if (drop_pkt_cnt[1] !== 32'd1) begin errors++; $display("FAIL stats_pkt: got %0d, required 1", drop_pkt_cnt[1]); end
        if (drop_byte_cnt[1] !== 32'd600) begin errors++; $display("FAIL stats_byte: got %0d, required 600", drop_byte_cnt[1]); end
        stats_clear = 1'b1;
        @(negedge core_clk);
        stats_clear = 1'b0;
        @(negedge core_clk);
        checks++;
        if (drop_pkt_cnt[1] !== 32'd0 || drop_byte_cnt[1] !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: got pkt=%0d byte=%0d, required 0 0", drop_pkt_cnt[1], drop_byte_cnt[1]);
        end
    endtask
`endif

    task automatic test_leak();
        @(negedge core_clk);
        bucket_decrement = {4{24'd100}};
        repeat (64) @(posedge core_clk);
        @(negedge core_clk);
        bucket_decrement = '0;
        checks += 2;
        if (bucket_level[1] !== 24'd800) begin errors++; $display("FAIL leak_level1: got %0d, required 800", bucket_level[1]); end
        if (bucket_level[0] !== 24'd2160) begin errors++; $display("FAIL leak_level0: got %0d, required 2160", bucket_level[0]); end
        send_pkt(2, 50, 0, 1, 0, f_acc, l_acc);
        wait_drain("leak");
        checks++;
        if (bucket_level[2] !== 24'd50) begin errors++; $display("FAIL leak_fill2: got %0d, required 50", bucket_level[2]); end
        bucket_decrement[2] = 24'd100;
        repeat (32) @(posedge core_clk);
        @(negedge core_clk);
        bucket_decrement = '0;
        checks++;
        if (bucket_level[2] !== 24'd0) begin errors++; $display("FAIL leak_floor2: got %0d, required 0", bucket_level[2]); end
    endtask

    task automatic test_add_and_tick();
        send_pkt(3, 500, 0, 1, 0, f_acc, l_acc);
        wait_drain("addtick");
        checks++;
        if (bucket_level[3] !== 24'd500) begin errors++; $display("FAIL addtick_fill3: got %0d, required 500", bucket_level[3]); end
        @(negedge core_clk);
        while ((cyc + 2) % 16 != 0) @(negedge core_clk);
        bucket_decrement[3] = 24'd100;
        send_pkt(3, 64, 0, 1, 0, f_acc, l_acc);
        bucket_decrement = '0;
        checks++;
        if ((f_acc + 1) % 16 != 0) begin errors++; $display("FAIL addtick_align: got accept edge %0d, required multiple of 16", f_acc + 1); end
        wait_drain("addtick2");
        checks++;
        if (bucket_level[3] !== 24'd464) begin errors++; $display("FAIL addtick_level3: got %0d, required 464", bucket_level[3]); end
    endtask

    task automatic test_back_to_back();
        int p0;
        policer_enable[2] = 1'b1;
        bucket_threshold[2] = 24'd0;
        mode = 1;
        send_pkt(0, 200, 0, 0, 0, f_acc, l_acc);
        send_pkt(0, 64, 0, 0, 0, f_acc, l_acc);
        send_pkt(0, 300, 0, 0, 0, f_acc, l_acc);
        mode = 2;
        repeat (2) @(negedge core_clk);
        p0 = pulses[2];
        send_pkt(2, 320, 1, 0, 0, f_acc, l_acc);
        checks++;
        if (l_acc - f_acc != 4) begin errors++; $display("FAIL drop_drain_rate: got %0d cycles, required 4", l_acc - f_acc); end
        mode = 0;
        wait_drain("b2b");
        checks += 2;
        if (pulses[2] - p0 != 1) begin errors++; $display("FAIL b2b_pulse: got %0d pulses, required 1", pulses[2] - p0); end
        if (bucket_level[2] !== 24'd0) begin errors++; $display("FAIL b2b_level2: got %0d, required 0", bucket_level[2]); end
    endtask

    task automatic test_reset_mid_packet();
        mode = 2;
        repeat (2) @(negedge core_clk);
        send_pkt(0, 320, 0, 0, 2, f_acc, l_acc);
        @(posedge core_clk); #1;
        in_if.tvalid = 1'b1;
        core_arstn = 1'b0;
        @(negedge core_clk);
        checks += 4;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b, required 0", out_if.tvalid); end
        if (in_if.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b, required 0", in_if.tready); end
        if (bucket_level !== '0) begin errors++; $display("FAIL mid_rst_level: got %h, required 0", bucket_level); end
        if (drop_pulse !== '0) begin errors++; $display("FAIL mid_rst_pulse: got %b, required 0", drop_pulse); end
        in_if.tvalid = 1'b0;
        sb.delete();
        mode = 0;
        repeat (2) @(negedge core_clk);
        core_arstn = 1'b1;
        send_pkt(0, 128, 0, 1, 0, f_acc, l_acc);
        wait_drain("post_rst");
        checks++;
        if (bucket_level[0] !== 24'd128) begin errors++; $display("FAIL post_rst_level0: got %0d, required 128", bucket_level[0]); end
    endtask

    initial begin
        test_reset();
        test_pass_bitexact();
        test_threshold_drop();
`ifdef P4_ROUTER_ING_POLICER_STATS_EN
        test_stats();
`endif
        test_leak();
        test_add_and_tick();
        test_back_to_back();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
